// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: PC-source mux loop, instruction-memory request/ack and
// decode valid/ready.
//   master : the fetch unit (drives pc, pc_plus4, imem_req/addr, ir_*)
//   slave  : surrounding datapath, memory and decode
interface pc_fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] next_pc;
  logic             pc_write;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             ir_valid;
  logic [31:0]      ir;
  logic [WIDTH-1:0] ir_pc;
  logic             ir_ready;

  modport master (
    input  next_pc, pc_write, imem_ack, imem_rdata, ir_ready,
    output pc, pc_plus4, imem_req, imem_addr, ir_valid, ir, ir_pc
  );

  modport slave (
    output next_pc, pc_write, imem_ack, imem_rdata, ir_ready,
    input  pc, pc_plus4, imem_req, imem_addr, ir_valid, ir, ir_pc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction-fetch sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_fetch_unit_if.master
//                next_pc/pc_write  redirect from the PC-source mux
//                pc, pc_plus4      current PC and its +4 (pc_plus4 is comb)
//                imem_*            request/ack fetch port, address held until ack
//                ir_*              fetched instruction to decode, valid/ready
module pc_fetch_unit #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] ir_pc_q, ir_pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] npc_al;

  assign pc_inc = pc_q + WIDTH'(4);
  // Redirect targets are word-aligned so PC[1:0] stays 00.
  assign npc_al = {bus.next_pc[WIDTH-1:2], 2'b00};

  // Next-state and datapath load decisions; a redirect outranks everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.pc_write) begin
          pc_d   = npc_al;
          addr_d = npc_al;
        end else begin
          addr_d = pc_q;
        end
      end

      REQ: begin
        if (bus.pc_write) begin
          pc_d = npc_al;
          // An unacknowledged request must keep its address; finish it in DISCARD.
          if (bus.imem_ack) addr_d  = npc_al;
          else              state_d = DISCARD;
        end else if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          ir_pc_d = addr_q;
          pc_d    = pc_inc;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (bus.pc_write) begin
          pc_d    = npc_al;
          addr_d  = npc_al;
          state_d = REQ;
        end else if (bus.ir_ready) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end

      DISCARD: begin
        if (bus.pc_write) pc_d = npc_al;
        if (bus.imem_ack) begin
          addr_d  = bus.pc_write ? npc_al : pc_q;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    req_d   = (state_d == REQ) || (state_d == DISCARD);
    valid_d = (state_d == HOLD);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_inc;
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.ir_valid  = valid_q;
  assign bus.ir        = ir_q;
  assign bus.ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed walk through fetch, stall, redirect,
// discard, wrap and mid-request reset, then randomized traffic checked by a
// stream-level model (decode must see a word-sequential stream restarting
// at every redirect, each word matching a fixed memory image).
module tb_pc_fetch_unit;

  localparam int unsigned WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pc_fetch_unit_if #(.WIDTH(WIDTH)) bus ();

  pc_fetch_unit #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction-memory image: a bijective scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input bit a, input bit r, input bit w, input logic [31:0] n);
    @(posedge clk);
    #1;
    bus.imem_ack   = a & bus.imem_req;
    bus.imem_rdata = bus.imem_ack ? memf(bus.imem_addr) : $urandom;
    bus.ir_ready   = r;
    bus.pc_write   = w;
    bus.next_pc    = n;
    @(negedge clk);
  endtask

  // Stream-level reference model and handshake properties.
  logic [31:0] exp_pc = RESET_PC;
  bit          p_ok   = 1'b0;
  logic        p_req, p_ack, p_valid, p_ready, p_pcw;
  logic [31:0] p_addr, p_npc, p_ir, p_irpc;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = RESET_PC;
      p_ok   = 1'b0;
    end else begin
      chk("pc_plus4", bus.pc_plus4, bus.pc + 32'd4);
      chk("pc_align", 32'(bus.pc[1:0]), 32'd0);
      chk("req_vs_valid", 32'(bus.imem_req & bus.ir_valid), 32'd0);
      if (p_ok) begin
        if (p_req && !p_ack) begin
          chk("req_hold", 32'(bus.imem_req), 32'd1);
          chk("addr_hold", bus.imem_addr, p_addr);
        end
        if (p_pcw) chk("redirect_pc", bus.pc, {p_npc[31:2], 2'b00});
        if (p_valid && !p_ready && !p_pcw) begin
          chk("ir_valid_hold", 32'(bus.ir_valid), 32'd1);
          chk("ir_hold", bus.ir, p_ir);
          chk("ir_pc_hold", bus.ir_pc, p_irpc);
        end
        if (p_valid && (p_ready || p_pcw)) chk("ir_gap", 32'(bus.ir_valid), 32'd0);
      end
      if (bus.ir_valid) chk("ir_data", bus.ir, memf(bus.ir_pc));
      if (bus.ir_valid && bus.ir_ready && !bus.pc_write) begin
        chk("ir_seq", bus.ir_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      if (bus.pc_write) exp_pc = {bus.next_pc[31:2], 2'b00};
      p_req   = bus.imem_req;
      p_ack   = bus.imem_ack;
      p_addr  = bus.imem_addr;
      p_valid = bus.ir_valid;
      p_ready = bus.ir_ready;
      p_pcw   = bus.pc_write;
      p_npc   = bus.next_pc;
      p_ir    = bus.ir;
      p_irpc  = bus.ir_pc;
      p_ok    = 1'b1;
    end
  end

  initial begin
    int acc0;
    logic [31:0] npc;
    bus.next_pc    = '0;
    bus.pc_write   = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.ir_ready   = 1'b0;

    // Reset values
    #12;
    chk("rst_pc", bus.pc, RESET_PC);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.ir_valid), 32'd0);
    chk("rst_ir", bus.ir, 32'd0);
    chk("rst_ir_pc", bus.ir_pc, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // First fetch, single-cycle ack
    cyc(1, 1, 0, 0);
    chk("t1_req", 32'(bus.imem_req), 32'd1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    chk("t1_novalid", 32'(bus.ir_valid), 32'd0);
    cyc(0, 1, 0, 0);
    chk("t1_valid", 32'(bus.ir_valid), 32'd1);
    chk("t1_ir_pc", bus.ir_pc, 32'h0);
    chk("t1_ir", bus.ir, memf(32'h0));
    chk("t1_pc", bus.pc, 32'h4);

    // Fetch at 0x4 acknowledged on its 4th request cycle
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0);
      chk("t2_req_wait", 32'(bus.imem_req), 32'd1);
      chk("t2_addr_wait", bus.imem_addr, 32'h4);
    end
    cyc(1, 0, 0, 0);
    chk("t2_req_ack", 32'(bus.imem_req), 32'd1);
    chk("t2_addr_ack", bus.imem_addr, 32'h4);
    cyc(0, 0, 0, 0);
    chk("t2_valid", 32'(bus.ir_valid), 32'd1);
    chk("t2_ir_pc", bus.ir_pc, 32'h4);
    chk("t2_ir", bus.ir, memf(32'h4));
    cyc(0, 1, 0, 0);
    chk("t2_held", bus.ir_pc, 32'h4);

    // Redirect while holding 0x8 unconsumed
    cyc(1, 0, 0, 0);
    chk("t3_addr8", bus.imem_addr, 32'h8);
    cyc(0, 0, 1, 32'h100);
    chk("t3_hold8", bus.ir_pc, 32'h8);
    cyc(1, 0, 0, 0);
    chk("t3_flush", 32'(bus.ir_valid), 32'd0);
    chk("t3_addr", bus.imem_addr, 32'h100);
    chk("t3_pc", bus.pc, 32'h100);
    cyc(0, 1, 0, 0);
    chk("t3_ir_pc", bus.ir_pc, 32'h100);

    // Redirects while a request is pending: stale address held, latest wins
    cyc(0, 0, 1, 32'h200);
    chk("t4_addr", bus.imem_addr, 32'h104);
    cyc(0, 0, 1, 32'h300);
    chk("t4_stale1", bus.imem_addr, 32'h104);
    chk("t4_pc200", bus.pc, 32'h200);
    cyc(0, 0, 1, 32'h400);
    chk("t4_stale2", bus.imem_addr, 32'h104);
    chk("t4_pc300", bus.pc, 32'h300);
    cyc(1, 0, 0, 0);
    chk("t4_stale3", bus.imem_addr, 32'h104);
    chk("t4_req", 32'(bus.imem_req), 32'd1);
    cyc(1, 0, 0, 0);
    chk("t5_addr400", bus.imem_addr, 32'h400);
    chk("t5_dropped", 32'(bus.ir_valid), 32'd0);
    cyc(0, 1, 1, 32'h103);
    chk("t5_ir_pc400", bus.ir_pc, 32'h400);
    cyc(0, 0, 1, 32'hFFFF_FFFF);
    chk("t5_align_pc", bus.pc, 32'h100);
    chk("t5_align_addr", bus.imem_addr, 32'h100);
    chk("t5_flush_rdy", 32'(bus.ir_valid), 32'd0);

    // Wrap at the top of the address space
    cyc(1, 0, 0, 0);
    chk("t5_pc_top", bus.pc, 32'hFFFF_FFFC);
    chk("t5_wrap", bus.pc_plus4, 32'h0);
    cyc(1, 0, 0, 0);
    chk("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0);
    chk("t5_ir_pc_top", bus.ir_pc, 32'hFFFF_FFFC);
    chk("t5_pc_wrapped", bus.pc, 32'h0);

    // Reset while a request is outstanding
    cyc(1, 0, 1, 32'h500);
    cyc(0, 0, 0, 0);
    chk("t6_pre_addr", bus.imem_addr, 32'h500);
    chk("t6_pre_req", 32'(bus.imem_req), 32'd1);
    #1 rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.ir_ready = 1'b0;
    #1;
    chk("t6_req", 32'(bus.imem_req), 32'd0);
    chk("t6_valid", 32'(bus.ir_valid), 32'd0);
    chk("t6_pc", bus.pc, RESET_PC);
    chk("t6_addr", bus.imem_addr, RESET_PC);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk("t6_restart_req", 32'(bus.imem_req), 32'd1);
    chk("t6_restart_addr", bus.imem_addr, RESET_PC);

    // Randomized traffic
    acc0 = n_acc;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) npc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                            npc = $urandom;
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 7, npc);
    end
    chk("progress", 32'((n_acc - acc0) > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
